// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared state encoding and default timing for the echo ranger
package echo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4
    } echo_state_t;

    localparam int DEF_CNT_W          = 16;
    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_TIMEOUT_CYCLES = 1_900_000;
    localparam int DEF_TICK_DIV       = 1;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge detect
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/echo_ranger.sv
// rtl/echo_ranger.sv - ultrasonic trigger/echo pulse-width ranger
module echo_ranger
    import echo_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TICK_DIV       = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] width,
    output logic             timeout,
    output logic             overflow
);

    localparam int TIMER_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TIMER_W-1:0] TRIG_LAST = TIMER_W'(TRIG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    echo_state_t        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               r_trig;
    logic               r_busy;
    logic               r_valid;
    logic [CNT_W-1:0]   r_width;
    logic               r_timeout;
    logic               r_overflow;

    logic w_echo_s;
    logic w_rise;

    sync_edge u_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (echo),
        .o_level (w_echo_s),
        .o_rise  (w_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pre      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_width    <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_TRIG;
                        r_trig  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                        r_count <= '0;
                        r_pre   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_TRIG: begin
                    if (r_timer == TRIG_LAST) begin
                        r_state <= ST_WAIT_RISE;
                        r_trig  <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        // The edge cycle is the first high cycle of the echo, so it is counted here.
                        r_state <= ST_MEASURE;
                        if (TICK_DIV == 1) begin
                            r_count <= CNT_W'(1);
                            r_pre   <= '0;
                        end else begin
                            r_count <= '0;
                            r_pre   <= PRE_W'(1);
                        end
                    end else if (r_timer == WAIT_LAST) begin
                        r_state    <= ST_DONE;
                        r_valid    <= 1'b1;
                        r_width    <= '0;
                        r_timeout  <= 1'b1;
                        r_overflow <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (!w_echo_s) begin
                        r_state    <= ST_DONE;
                        r_valid    <= 1'b1;
                        r_width    <= r_count;
                        r_timeout  <= 1'b0;
                        r_overflow <= r_ovf;
                    end else if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                        if (r_count == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else begin
                        r_pre <= r_pre + PRE_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign trig     = r_trig;
    assign busy     = r_busy;
    assign valid    = r_valid;
    assign width    = r_width;
    assign timeout  = r_timeout;
    assign overflow = r_overflow;

endmodule
